// File: rtl/stall_buffer_if.sv
// stall_buffer_if: upstream push and downstream pop handshake of the stall buffer
interface stall_buffer_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  in_valid;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  out_valid;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_ready;
   modport master (output in_valid, in_data, out_ready, input out_valid, out_data);
   modport slave  (input in_valid, in_data, out_ready, output out_valid, out_data);
endinterface

// File: rtl/stall_buffer.sv
// stall_buffer: elastic FIFO that absorbs in-flight data while a global stall propagates
module stall_buffer #(
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH       = 8,
   parameter int SLACK       = 2,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   stall_buffer_if.slave          bus,
   input  logic                   stall_in,
   output logic                   buf_full,
   output logic [$clog2(DEPTH):0] buf_count,
   output logic                   overflow,
   output logic [STALL_CNT_W-1:0] stall_cycles
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
   localparam logic [AW:0] THRESH   = (AW+1)'(DEPTH - SLACK);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         rd_ptr, wr_ptr;
   logic [AW:0]           count;
   logic                  out_valid, push, pop;

   // Head is exposed straight from storage; empty forces zero so reset shows out_data=0
   assign out_valid     = count != '0;
   assign bus.out_valid = out_valid;
   assign bus.out_data  = out_valid ? mem[rd_ptr] : '0;
   assign pop           = out_valid & bus.out_ready;
   // A full FIFO still accepts when the head leaves in the same cycle
   assign push          = bus.in_valid & (count < FULL_LVL | pop);
   // Full is raised early so the registered stall reaches upstream before data is lost
   assign buf_full      = count >= THRESH;
   assign buf_count     = count;

   // Storage write; contents need no reset
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= bus.in_data;

   // Pointers, occupancy, sticky drop flag and saturating stall statistics
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         count        <= '0;
         overflow     <= 1'b0;
         stall_cycles <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= (push & ~pop) ? count + 1'b1 : (pop & ~push) ? count - 1'b1 : count;
         if (bus.in_valid & ~push) overflow <= 1'b1;
         if (stall_in && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
      end
endmodule

// File: tb/tb_stall_buffer.sv
// tb_stall_buffer: scoreboard bench for the stall buffer, plus a narrow-counter instance for saturation
module tb_stall_buffer;
   logic        clk = 1'b0, reset = 1'b1, stall_in = 1'b0, stall_sat = 1'b0;
   logic        buf_full, overflow, full_s, ovf_s;
   logic [3:0]  buf_count, count_s, stall_s;
   logic [15:0] stall_cycles;
   logic        loop_en = 1'b0, st_manual = 1'b0, m_ovf = 1'b0, v, sp;
   int          m_stall = 0, n_tests = 0, n_fail = 0;
   logic [31:0] sb [$];

   stall_buffer_if #(.DATA_WIDTH(32)) bus ();
   stall_buffer_if #(.DATA_WIDTH(8))  bus_s ();

   stall_buffer dut (
      .clk(clk), .reset(reset), .bus(bus), .stall_in(stall_in), .buf_full(buf_full),
      .buf_count(buf_count), .overflow(overflow), .stall_cycles(stall_cycles)
   );

   stall_buffer #(.DATA_WIDTH(8), .STALL_CNT_W(4)) u_sat (
      .clk(clk), .reset(reset), .bus(bus_s), .stall_in(stall_sat), .buf_full(full_s),
      .buf_count(count_s), .overflow(ovf_s), .stall_cycles(stall_s)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock: drive, compare against the model at negedge, update the model, advance
   task automatic step(input logic vi, input logic [31:0] d, input logic r);
      logic exp_pop, exp_push, exp_full;
      logic [31:0] exp_d;
      bus.in_valid = vi;
      bus.in_data = d;
      bus.out_ready = r;
      @(negedge clk);
      exp_full = sb.size() >= 6;
      check("out_valid", bus.out_valid, sb.size() != 0);
      check("buf_count", buf_count, sb.size());
      check("buf_full", buf_full, exp_full);
      check("overflow", overflow, m_ovf);
      check("stall_cycles", stall_cycles, m_stall);
      exp_pop = r && sb.size() != 0;
      exp_push = vi && (sb.size() < 8 || exp_pop);
      if (exp_pop) begin
         exp_d = sb.pop_front();
         check("out_data", bus.out_data, exp_d);
      end
      if (exp_push) sb.push_back(d);
      if (vi && !exp_push) m_ovf = 1'b1;
      if (stall_in) m_stall++;
      @(posedge clk);
      #1 stall_in = loop_en ? exp_full : st_manual;
   endtask

   initial begin
      bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 0;
      bus_s.in_valid = 0; bus_s.in_data = '0; bus_s.out_ready = 0;
      #12;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_data", bus.out_data, 0);
      check("rst_buf_count", buf_count, 0);
      @(posedge clk);
      #1 reset = 1'b0;

      // Mid-stream asynchronous reset with five entries and a running stall count
      st_manual = 1'b1;
      stall_in = 1'b1;
      for (int i = 0; i < 5; i++) step(1'b1, 32'h10 + i, 1'b0);
      #2 check("pre_rst_count", buf_count, 5);
      reset = 1'b1;
      #1;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_buf_count", buf_count, 0);
      check("rst_buf_full", buf_full, 0);
      check("rst_overflow", overflow, 0);
      check("rst_stall_cycles", stall_cycles, 0);
      check("rst_out_data", bus.out_data, 0);
      sb.delete();
      m_stall = 0;
      st_manual = 1'b0;
      stall_in = 1'b0;
      @(posedge clk);
      #1 reset = 1'b0;
      step(1'b1, 32'hA5, 1'b0);
      check("a5_head", bus.out_data, 32'hA5);
      step(1'b0, 0, 1'b1);
      step(1'b0, 0, 1'b0);

      // Wrap-around: continuous push and pop through the pointer wrap
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 32'h200 + i, 1'b1);
         check("wrap_count_le1", buf_count <= 1, 1);
      end
      step(1'b0, 0, 1'b1);
      step(1'b0, 0, 1'b0);

      // Stall loop: stall_in is buf_full delayed a cycle; upstream stops one cycle later
      loop_en = 1'b1;
      sp = 1'b0;
      for (int i = 0; i < 16; i++) begin
         v = !sp;
         sp = stall_in;
         step(v, 32'h300 + i, 1'b0);
         check("loop_peak_le8", buf_count <= 8, 1);
      end
      for (int i = 0; i < 10; i++) step(1'b0, 0, 1'b1);
      loop_en = 1'b0;
      step(1'b0, 0, 1'b0);
      check("loop_stall_total", stall_cycles, m_stall);

      // Fill to full, then simultaneous push and pop while full
      for (int i = 1; i <= 8; i++) step(1'b1, i, 1'b0);
      check("fill_count", buf_count, 8);
      step(1'b1, 32'h99, 1'b1);
      check("full_pp_count", buf_count, 8);
      check("full_pp_ovf", overflow, 0);

      // Overflow: push on full with no pop is dropped and sticks
      step(1'b1, 32'h77, 1'b0);
      step(1'b0, 0, 1'b0);
      for (int i = 0; i < 8; i++) step(1'b0, 0, 1'b1);
      step(1'b0, 0, 1'b0);
      check("ovf_sticky", overflow, 1);

      // Saturation of a 4-bit stall counter
      stall_sat = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1 check("sat_count", stall_s, (i + 1 < 15) ? i + 1 : 15);
      end
      stall_sat = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/stall_buffer.md
Name: stall_buffer

Overview:
- Elastic FIFO stage between a producing pipeline stage and its consumer.
- Absorbs in-flight data while a global stall propagates, and drives the buffer-full indication consumed by the stall management register.
- Stall management adds one registered cycle of latency before upstream sees the stall. The buffer therefore raises its full flag with SLACK entries of headroom, so no data is lost.

Parameters:
- DATA_WIDTH, 32: width of the data payload.
- DEPTH, 8: FIFO entries. Must be a power of two and ≥ 4.
- SLACK, 2: free entries still remaining when buf_full asserts. Legal range 1..DEPTH-1.
- STALL_CNT_W, 16: width of the saturating stall-cycle counter.

Ports:
- clk, input, 1: clock. All state updates on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- in_valid, input, 1: upstream presents in_data this cycle.
- in_data, input, DATA_WIDTH: upstream payload.
- stall_in, input, 1: registered global stall from stall management. Used only for statistics; it does not gate push or pop.
- out_valid, output, 1: FIFO head is valid.
- out_data, output, DATA_WIDTH: FIFO head payload.
- out_ready, input, 1: downstream accepts the head this cycle.
- buf_full, output, 1: occupancy ≥ DEPTH-SLACK. Feeds stall management.
- buf_count, output, clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- overflow, output, 1: sticky flag; set when a push was dropped.
- stall_cycles, output, STALL_CNT_W: saturating count of cycles with stall_in=1.

Behaviour:
- Reset (asynchronous, immediate):
  - read pointer, write pointer and count = 0
  - out_valid=0, buf_full=0, overflow=0, stall_cycles=0
  - out_data = 0
  - Storage contents are don't-care.
- Pop:
  - pop = out_valid & out_ready.
  - out_valid = (count != 0).
  - out_data = entry at the read pointer, read combinationally from registered storage.
- Push:
  - push = in_valid & (count < DEPTH | pop). A push is accepted on a full FIFO if a pop happens in the same cycle.
- Write: on push, store in_data at the write pointer, then advance it modulo DEPTH (natural wrap).
- Read: on pop, advance the read pointer modulo DEPTH.
- Count update:
  - push & !pop: +1
  - pop & !push: -1
  - both or neither: unchanged.
- Latency: data pushed in cycle N is visible on out_data/out_valid in cycle N+1. There is no bypass; an empty FIFO never forwards in_data in the same cycle.
- Simultaneous push and pop on an empty FIFO cannot occur, because out_valid=0 when empty.
- buf_full:
  - Combinational from the registered count: buf_full = (count ≥ DEPTH-SLACK).
  - Deasserts the same cycle count drops below the threshold.
- Overflow:
  - Condition: in_valid=1 while count=DEPTH and no pop.
  - The data is dropped; pointers and count are unchanged.
  - overflow sets to 1 on the next edge and holds until reset.
- stall_cycles:
  - Increments on each edge where stall_in=1.
  - Saturates at all-ones with no wrap.
- Reset mid-operation:
  - All occupancy is discarded and out_valid drops immediately (asynchronous).
  - The first push after reset release lands at entry 0.
- Upstream contract: upstream deasserts in_valid within 1 cycle of stall_in rising. With SLACK ≥ 2, worst-case in-flight pushes never overflow, given the 1-cycle stall_mgmt register plus the 1-cycle response.

Test Plan:
- Reset check:
  - Stimulus: assert reset mid-stream with count=5.
  - Required: out_valid=0, buf_count=0, buf_full=0 and overflow=0 immediately; stall_cycles=0.
  - Then push 0xA5 after release: out_data=0xA5 and out_valid=1 one cycle later.
- Fill and drain:
  - Stimulus: out_ready=0, push 0x01..0x08 (DEPTH=8, SLACK=2).
  - Required: buf_full rises when buf_count=6; buf_count=8 at the end.
  - Then out_ready=1: pops 0x01..0x08 in order, buf_full falls when buf_count=5, out_valid falls after the 8th pop.
- Full with simultaneous push and pop:
  - Stimulus: count=8, in_valid=1 with 0x99, out_ready=1.
  - Required: head popped, 0x99 accepted, buf_count stays 8, overflow stays 0.
- Overflow:
  - Stimulus: count=8, out_ready=0, in_valid=1 with 0x77.
  - Required: 0x77 dropped, buf_count=8, overflow=1 from the next cycle and persisting.
  - Later pops return only the original 8 entries.
- Wrap-around:
  - Stimulus: 20 back-to-back pushes of an incrementing pattern with out_ready=1 continuously.
  - Required: out_data matches the input sequence with 1-cycle latency, buf_count ≤ 1 throughout, no overflow.
- Stall loop:
  - Stimulus: connect buf_full through a 1-cycle register to stall_in; upstream stops pushing 1 cycle after stall_in; out_ready=0.
  - Required: no overflow, buf_count peaks ≤ 8, and stall_cycles counts stall_in-high cycles exactly.
  - Saturation: force STALL_CNT_W=4 with 20 stall cycles; stall_cycles holds at 15.
